interrupt_controller: RTL

External interrupt controller feeding the Kabeta core's `EIC_I_Req`/`EIC_I_Id` inputs. It synchronizes up to `NUM_SRC` asynchronous interrupt lines and latches them as pending, per-source edge- or level-triggered. It arbitrates among unmasked pending sources round-robin and holds one request to the core until software signals end-of-interrupt (EOI). Software reaches it through a small register port driven by the system I/O decoder.

---
 rtl/eic_pkg.sv | 19 +
 rtl/eic_rr_arbiter.sv | 32 +++
 rtl/interrupt_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/eic_pkg.sv
// eic_pkg: shared constants for the external interrupt controller.
//   - Register address map for the 2-bit register select.
//   - FSM state encoding.
//   - Bit position of the InService flag in the STAT register.
package eic_pkg;

  localparam logic [1:0] EIC_PEND = 2'd0;
  localparam logic [1:0] EIC_MASK = 2'd1;
  localparam logic [1:0] EIC_EDGE = 2'd2;
  localparam logic [1:0] EIC_STAT = 2'd3;

  typedef enum logic [0:0] {
    EIC_IDLE = 1'b0,
    EIC_REQ  = 1'b1
  } eic_state_t;

  localparam int unsigned EIC_STAT_INSVC_BIT = 31;

endpackage

// File: rtl/eic_rr_arbiter.sv
// eic_rr_arbiter: combinational round-robin arbiter.
// The search starts at Last_Id+1 and wraps modulo NUM_SRC, so the most
// recently serviced source has the lowest priority.
//   Req_Vec     in   NUM_SRC  unmasked pending sources
//   Last_Id     in   ID_W     id of the most recently serviced source
//   Grant_Valid out  1        at least one request present
//   Grant_Id    out  ID_W     winning source (0 when Grant_Valid=0)
module eic_rr_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] Req_Vec,
  input  logic [ID_W-1:0]    Last_Id,
  output logic               Grant_Valid,
  output logic [ID_W-1:0]    Grant_Id
);

  always_comb begin : search
    logic [ID_W-1:0] cand;
    cand        = '0;
    Grant_Valid = 1'b0;
    Grant_Id    = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = ID_W'((32'(Last_Id) + k) % NUM_SRC);
      if (!Grant_Valid && Req_Vec[cand]) begin
        Grant_Valid = 1'b1;
        Grant_Id    = cand;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: external interrupt controller for the core's
// EIC_I_Req / EIC_I_Id inputs. Synchronizes NUM_SRC asynchronous lines,
// latches them as pending (edge or level per source), arbitrates round-robin
// among unmasked pending sources and holds one request until software EOI.
//   Sys_Clock  in   1        system clock, rising edge
//   Sys_Reset  in   1        asynchronous active-high reset
//   Irq_Src    in   NUM_SRC  raw interrupt lines (asynchronous)
//   Reg_EnR    in   1        register read strobe
//   Reg_EnW    in   1        register write strobe
//   Reg_Addr   in   2        0 PEND (W1C), 1 MASK, 2 EDGE, 3 STAT/EOI
//   Reg_DataW  in   32       write data
//   Reg_DataR  out  32       registered read data
//   EIC_I_Req  out  1        registered request to the core
//   EIC_I_Id   out  ID_W     requesting source id
module interrupt_controller
  import eic_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Irq_Src,
  input  logic               Reg_EnR,
  input  logic               Reg_EnW,
  input  logic [1:0]         Reg_Addr,
  input  logic [31:0]        Reg_DataW,
  output logic [31:0]        Reg_DataR,
  output logic               EIC_I_Req,
  output logic [ID_W-1:0]    EIC_I_Id
);

  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_pend_edge;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_edge;
  eic_state_t         r_state;
  logic               r_req;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last_id;
  logic [31:0]        r_data_r;

  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_eoi_sel;
  logic               w_wr_pend;
  logic               w_wr_mask;
  logic               w_wr_edge;
  logic               w_eoi;
  logic               w_grant_valid;
  logic [ID_W-1:0]    w_grant_id;
  logic [31:0]        w_stat;
  logic [31:0]        w_rd_data;
  logic               w_unused;

  // ---------------------------------------------------------------------
  // Write decode; EOI only has an effect while a request is outstanding
  // ---------------------------------------------------------------------
  assign w_wr_pend = Reg_EnW && (Reg_Addr == EIC_PEND);
  assign w_wr_mask = Reg_EnW && (Reg_Addr == EIC_MASK);
  assign w_wr_edge = Reg_EnW && (Reg_Addr == EIC_EDGE);
  assign w_eoi     = Reg_EnW && (Reg_Addr == EIC_STAT) && (r_state == EIC_REQ);

  assign w_unused  = ^Reg_DataW[31:NUM_SRC];

  // ---------------------------------------------------------------------
  // Input path: 2-FF synchronizer plus previous-value register
  // ---------------------------------------------------------------------
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= Irq_Src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise    = r_sync2 & ~r_prev & r_edge;
  assign w_eoi_sel = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_id;
  assign w_clr     = (w_wr_pend ? Reg_DataW[NUM_SRC-1:0] : '0) |
                     (w_eoi     ? w_eoi_sel              : '0);

  // Set is OR-ed in after clearing so a coincident edge always wins over a
  // W1C or EOI. Masking with r_edge drops stale bits when a source is
  // reconfigured to level.
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_pend_edge <= '0;
    end else begin
      r_pend_edge <= ((r_pend_edge & ~w_clr) | w_rise) & r_edge;
    end
  end

  // Level sources follow the synchronized line directly
  assign w_pend = r_pend_edge | (~r_edge & r_sync2);

  // ---------------------------------------------------------------------
  // MASK / EDGE registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      if (w_wr_mask) begin
        r_mask <= Reg_DataW[NUM_SRC-1:0];
      end
      if (w_wr_edge) begin
        r_edge <= Reg_DataW[NUM_SRC-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Arbitration and request FSM
  // ---------------------------------------------------------------------
  eic_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .Req_Vec     (w_pend & r_mask),
    .Last_Id     (r_last_id),
    .Grant_Valid (w_grant_valid),
    .Grant_Id    (w_grant_id)
  );

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_state   <= EIC_IDLE;
      r_req     <= 1'b0;
      r_id      <= '0;
      r_last_id <= ID_W'(NUM_SRC - 1);
    end else begin
      case (r_state)
        EIC_IDLE: begin
          if (w_grant_valid) begin
            r_req   <= 1'b1;
            r_id    <= w_grant_id;
            r_state <= EIC_REQ;
          end
        end
        EIC_REQ: begin
          if (w_eoi) begin
            r_req     <= 1'b0;
            r_last_id <= r_id;
            r_state   <= EIC_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= EIC_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read path: sampled from current (pre-write) register values
  // ---------------------------------------------------------------------
  always_comb begin
    w_stat                     = '0;
    w_stat[EIC_STAT_INSVC_BIT] = (r_state == EIC_REQ);
    w_stat[ID_W-1:0]           = r_id;
  end

  always_comb begin
    w_rd_data = '0;
    case (Reg_Addr)
      EIC_PEND: w_rd_data = 32'(w_pend);
      EIC_MASK: w_rd_data = 32'(r_mask);
      EIC_EDGE: w_rd_data = 32'(r_edge);
      default:  w_rd_data = w_stat;
    endcase
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_data_r <= '0;
    end else if (Reg_EnR) begin
      r_data_r <= w_rd_data;
    end
  end

  assign Reg_DataR = r_data_r;
  assign EIC_I_Req = r_req;
  assign EIC_I_Id  = r_id;

endmodule
